// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V fetch path: responder state, instruction word, default NOP.
package riscv_pkg;

  typedef enum logic {LOAD, RUN} imem_state_t;

  typedef logic [31:0] word_t;

  // addi x0,x0,0
  localparam word_t DEFAULT_NOP_INS = 32'h0000_0013;

endpackage

// File: rtl/imem_ram.sv
// Single-port instruction RAM; the port address follows the loader while loading and the fetch index otherwise.
module imem_ram
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter word_t       FILL        = DEFAULT_NOP_INS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           loading,
  input  logic                           we,
  input  logic                           rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [$clog2(DEPTH_WORDS)-1:0] fetch_addr,
  input  word_t                          wdata,
  output word_t                          rdata
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  word_t          mem [DEPTH_WORDS];
  logic [AW-1:0]  addr;

  assign addr = loading ? ld_addr : fetch_addr;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register doubles as the output register: FILL whenever no real word is returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= FILL;
    end else begin
      rdata <= rd_en ? mem[addr] : FILL;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: loader fills the RAM in LOAD, then PC fetches are answered one cycle later in RUN.
module imem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter word_t       BASE_ADDR   = 32'h0000_0000,
  parameter word_t       NOP_INS     = DEFAULT_NOP_INS
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data,
  input  logic                           ld_last,
  input  logic                           reload,
  input  logic [31:0]                    PC,
  output logic [31:0]                    mem_ins,
  output logic                           ins_valid,
  output logic                           fault,
  output logic                           fault_sticky,
  output logic [31:0]                    fetch_count,
  output logic                           busy_loading
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam word_t       SPAN = word_t'(4 * DEPTH_WORDS);

  imem_state_t state;
  word_t       off;
  logic        loading;
  logic        fetch_ok;
  logic        ram_we;
  logic        ram_rd;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
  assign off      = PC - BASE_ADDR;
  assign fetch_ok = (PC[1:0] == 2'b00) && (off < SPAN);
  assign loading  = (state == LOAD);
  assign ram_we   = loading && ld_valid;
  assign ram_rd   = (state == RUN) && !reload && fetch_ok;

  assign ld_ready     = loading;
  assign busy_loading = loading;

  imem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .FILL        (NOP_INS)
  ) u_ram (
    .clk        (clock),
    .rst_n      (reset),
    .loading    (loading),
    .we         (ram_we),
    .rd_en      (ram_rd),
    .ld_addr    (ld_addr),
    .fetch_addr (off[AW+1:2]),
    .wdata      (ld_data),
    .rdata      (mem_ins)
  );

  // Load/run sequencing with fetch status and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= LOAD;
      ins_valid    <= 1'b0;
      fault        <= 1'b0;
      fault_sticky <= 1'b0;
      fetch_count  <= '0;
    end else begin
      case (state)
        LOAD: begin
          ins_valid <= 1'b0;
          fault     <= 1'b0;
          if (ld_valid && ld_last) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (reload) begin
            state        <= LOAD;
            ins_valid    <= 1'b0;
            fault        <= 1'b0;
            fault_sticky <= 1'b0;
            fetch_count  <= '0;
          end else if (fetch_ok) begin
            ins_valid   <= 1'b1;
            fault       <= 1'b0;
            fetch_count <= fetch_count + 32'd1;
          end else begin
            ins_valid    <= 1'b0;
            fault        <= 1'b1;
            fault_sticky <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Randomized bench for imem_responder against a behavioural memory model, plus literal checks from the fetch scenarios.
module tb_imem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_last = 1'b0;
  logic          reload = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_data = '0;
  logic [31:0]   pc = '0;
  logic          ld_ready, ins_valid, fault, fault_sticky, busy_loading;
  logic [31:0]   mem_ins, fetch_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  imem_responder dut (
    .clock        (clk),
    .reset        (rst_n),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .reload       (reload),
    .PC           (pc),
    .mem_ins      (mem_ins),
    .ins_valid    (ins_valid),
    .fault        (fault),
    .fault_sticky (fault_sticky),
    .fetch_count  (fetch_count),
    .busy_loading (busy_loading)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
  endfunction

  // Behavioural model: an array of words plus a loading flag, updated per clock from the rules.
  logic [31:0] m_ram [DEPTH];
  bit          m_known [DEPTH];
  bit          m_loading = 1'b1;
  bit          m_valid = 1'b0;
  bit          m_fault = 1'b0;
  bit          m_sticky = 1'b0;
  bit          m_ins_known = 1'b1;
  logic [31:0] m_ins = NOP;
  logic [31:0] m_count = '0;
  logic [31:0] m_off;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 1'b1; m_ins = NOP; m_ins_known = 1'b1;
      m_valid = 1'b0; m_fault = 1'b0; m_sticky = 1'b0; m_count = '0;
    end else if (m_loading) begin
      if (ld_valid) begin
        m_ram[ld_addr]   = ld_data;
        m_known[ld_addr] = 1'b1;
        if (ld_last) m_loading = 1'b0;
      end
      m_ins = NOP; m_ins_known = 1'b1; m_valid = 1'b0; m_fault = 1'b0;
    end else if (reload) begin
      m_loading = 1'b1; m_ins = NOP; m_ins_known = 1'b1;
      m_valid = 1'b0; m_fault = 1'b0; m_sticky = 1'b0; m_count = '0;
    end else begin
      m_off = pc - BASE;
      if ((pc % 4 == 0) && (m_off < 4 * DEPTH)) begin
        m_ins = m_ram[m_off / 4]; m_ins_known = m_known[m_off / 4];
        m_valid = 1'b1; m_fault = 1'b0; m_count = m_count + 32'd1;
      end else begin
        m_ins = NOP; m_ins_known = 1'b1;
        m_valid = 1'b0; m_fault = 1'b1; m_sticky = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    chk("busy_loading", 32'(busy_loading), 32'(m_loading));
    if (rst_n) chk("ld_ready", 32'(ld_ready), 32'(m_loading));
    chk("ins_valid", 32'(ins_valid), 32'(m_valid));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_sticky", 32'(fault_sticky), 32'(m_sticky));
    chk("fetch_count", fetch_count, m_count);
    if (m_ins_known) chk("mem_ins", mem_ins, m_ins);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d, input bit last);
    if ($urandom_range(0, 3) == 0) begin
      ld_valid = 1'b0; ld_last = 1'($urandom); ld_data = $urandom; ld_addr = AW'($urandom);
      tick();
    end
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    reload = 1'($urandom_range(0, 1));
    tick();
    ld_valid = 1'b0; ld_last = 1'b0; reload = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    pc = a;
    tick();
  endtask

  task automatic random_run(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0, 1:    a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        2:       a = 32'($urandom_range(0, 4 * DEPTH - 1));
        3:       a = $urandom();
        default: a = (k % 2 == 1) ? 32'hFFFF_FFFC : 32'(4 * DEPTH) + 32'($urandom_range(0, 3)) * 32'd4;
      endcase
      ld_valid = 1'($urandom); ld_addr = AW'($urandom); ld_data = $urandom;
      fetch(a);
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] img [DEPTH];
    logic [31:0] img2 [4];

    repeat (3) tick();
    chk("rst_busy", 32'(busy_loading), 32'd1);
    chk("rst_mem_ins", mem_ins, NOP);
    chk("rst_count", fetch_count, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("load_ld_ready", 32'(ld_ready), 32'd1);

    for (int i = 4; i < DEPTH; i++) img[i] = $urandom;
    img[0] = 32'h00500093; img[1] = 32'h00A00113;
    img[2] = 32'h002081B3; img[3] = 32'h00000013;
    for (int i = 4; i < DEPTH; i++) load_word(AW'(i), img[i], 1'b0);
    for (int i = 0; i < 4; i++) load_word(AW'(i), img[i], i == 3);

    fetch(32'd0);  chk("pc0", mem_ins, 32'h00500093);
    fetch(32'd4);  chk("pc4", mem_ins, 32'h00A00113);
    fetch(32'd8);  chk("pc8", mem_ins, 32'h002081B3);
    fetch(32'd12); chk("pc12", mem_ins, 32'h00000013);
    chk("pc12_valid", 32'(ins_valid), 32'd1);
    chk("count4", fetch_count, 32'd4);

    fetch(32'h0000_0002);
    chk("mis_ins", mem_ins, NOP);
    chk("mis_valid", 32'(ins_valid), 32'd0);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_sticky", 32'(fault_sticky), 32'd1);
    chk("mis_count", fetch_count, 32'd4);

    fetch(32'h0000_0400);
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_ins", mem_ins, NOP);
    fetch(32'h0000_03FC);
    chk("top_ins", mem_ins, img[255]);
    chk("top_fault", 32'(fault), 32'd0);

    ld_valid = 1'b1; ld_addr = '0; ld_data = 32'hDEADBEEF;
    fetch(32'd0);
    chk("run_ld_ready", 32'(ld_ready), 32'd0);
    fetch(32'd0);
    chk("run_no_write", mem_ins, 32'h00500093);
    ld_valid = 1'b0;

    random_run(200);

    reload = 1'b1; tick(); reload = 1'b0;
    chk("reload_busy", 32'(busy_loading), 32'd1);
    chk("reload_count", fetch_count, 32'd0);
    chk("reload_sticky", 32'(fault_sticky), 32'd0);
    load_word(AW'(1), 32'h00100073, 1'b1);
    fetch(32'd0);
    chk("reload_pc0", mem_ins, 32'h00500093);
    chk("reload_count1", fetch_count, 32'd1);
    fetch(32'd4);
    chk("reload_pc4", mem_ins, 32'h00100073);
    chk("reload_count2", fetch_count, 32'd2);

    pc = 32'd8;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(ins_valid), 32'd0);
    chk("async_ins", mem_ins, NOP);
    chk("async_count", fetch_count, 32'd0);
    chk("async_busy", 32'(busy_loading), 32'd1);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) img2[i] = $urandom;
    load_word(AW'(0), img2[0], 1'b0);
    load_word(AW'(1), img2[1], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midload_busy", 32'(busy_loading), 32'd1);
    chk("midload_ins", mem_ins, NOP);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) load_word(AW'(i), img2[i], i == 3);
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i) * 32'd4);
      chk("final_fetch", mem_ins, img2[i]);
    end

    random_run(200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder for the RISC-V pipeline. It is the memory end of the fetch interface: the core drives PC, and this block returns mem_ins.
- Contains a word-addressed instruction RAM. A valid/ready loader port fills the RAM from the testbench or a boot source before execution starts.
- Sits between the loader/testbench and the core's IF stage. It answers fetches with a 1-cycle registered read.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words (power of two, ≥4).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- NOP_INS, 32'h0000_0013, word returned when no valid instruction exists (addi x0,x0,0).

Ports:
- clock  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  block accepts loader word.
- ld_addr  in  $clog2(DEPTH_WORDS)  word index to write.
- ld_data  in  32  instruction word.
- ld_last  in  1  final word of image; qualifies with ld_valid.
- reload  in  1  single-cycle request to return to loading.
- PC  in  32  byte fetch address from core.
- mem_ins  out  32  instruction for the PC sampled on the previous edge.
- ins_valid  out  1  mem_ins holds a real RAM word.
- fault  out  1  previous-cycle PC was misaligned or out of range.
- fault_sticky  out  1  a fault has occurred since the last reset or reload.
- fetch_count  out  32  number of RUN cycles that returned a valid word.
- busy_loading  out  1  state is LOAD.

Behaviour:
- Reset (reset==0, async):
  - State = LOAD; mem_ins = NOP_INS; ins_valid = 0; fault = 0; fault_sticky = 0; fetch_count = 0.
  - ld_ready = 1 once reset deasserts.
  - RAM contents are not cleared.
- States: LOAD, RUN.
- LOAD:
  - ld_ready = 1. A word is written when ld_valid && ld_ready, at RAM[ld_addr], on the same edge.
  - If that handshake also has ld_last = 1, go to RUN on that edge. The last word is written before the first fetch.
  - Outputs held at mem_ins = NOP_INS, ins_valid = 0, fault = 0.
- RUN:
  - ld_ready = 0; ld_valid is ignored and no writes occur.
  - Each edge samples PC and computes off = PC − BASE_ADDR (32-bit, wraps modulo 2^32).
  - Valid fetch: PC[1:0] == 0 and off < 4·DEPTH_WORDS. Then mem_ins ← RAM[off[$clog2(DEPTH_WORDS)+1:2]], ins_valid ← 1, fault ← 0, fetch_count += 1.
  - Otherwise: mem_ins ← NOP_INS, ins_valid ← 0, fault ← 1, fault_sticky ← 1, and fetch_count is unchanged.
  - Latency is exactly 1 cycle from PC to mem_ins. There is no stall or back-pressure.
- fetch_count wraps from 2^32−1 to 0.
- reload = 1 in RUN:
  - Next edge goes to LOAD; mem_ins ← NOP_INS; ins_valid ← 0; fault ← 0.
  - fault_sticky and fetch_count clear.
  - RAM is retained, so a partial reload overwrites only the words written.
- reload in LOAD has no effect.
- If reload and ld_valid&&ld_last land on the same edge in LOAD, the write happens and the state goes to RUN.
- Reset asserted mid-load: the state aborts to LOAD; words written before reset are retained.
- Reset asserted in RUN: the outputs take their reset values immediately, not at the next edge.
- Writes only occur in LOAD, so a same-address read/write collision cannot happen.

Decomposition:
- Shared package riscv_pkg holds:
  - typedef enum logic {LOAD, RUN} imem_state_t;
  - localparam NOP_INS default;
  - typedef logic [31:0] word_t.
- One sub-module is natural: imem_ram. It is a single-port synchronous RAM (write enable, address, wdata, registered rdata) with the address mux selecting the ld_addr or PC index by state.
- The FSM, range/alignment check and counters stay in the top level.

Test Plan:
- Load words 0..3 = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013, with ld_last on word 3. Then drive PC = 0, 4, 8, 12 → mem_ins matches each word one cycle later, ins_valid = 1, fetch_count = 4.
- In RUN, drive PC = 32'h0000_0002 → next cycle mem_ins = 32'h00000013, ins_valid = 0, fault = 1, fault_sticky = 1, fetch_count unchanged.
- With DEPTH_WORDS = 256, drive PC = 32'h0000_0400 and PC = 32'h0000_03FC → first gives fault = 1 and NOP; second returns RAM[255] with fault = 0.
- Hold ld_valid = 1 in RUN with ld_addr = 0, ld_data = 32'hDEADBEEF, then fetch PC = 0 → ld_ready = 0 and the original word 32'h00500093 is returned.
- Assert reload, load word 1 = 32'h00100073 with ld_last, fetch PC = 0 and 4 → PC 0 returns the old word, PC 4 returns 32'h00100073, and fetch_count restarts from 0.
- Assert reset mid-load after 2 of 4 words, deassert, reload all 4 → busy_loading = 1 immediately on reset, mem_ins = NOP asynchronously, and the final fetch data is correct.
